// File: rtl/npu_pkg.sv
// Shared NPU definitions: default element widths for the result path and the
// state encoding used by the result requantizer's frame FSM.
package npu_pkg;

    localparam int NPU_IN_W    = 16;  // accumulator element width
    localparam int NPU_OUT_W   = 8;   // requantized element width
    localparam int NPU_SHIFT_W = 4;   // shift-control width
    localparam int NPU_ELEMS   = 16;  // 4x4 result tile

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        FIN    = 2'd3
    } rq_state_e;

endpackage

// File: rtl/result_requantizer_if.sv
// Output stream of the result requantizer: one requantized element per
// out_valid/out_ready handshake, tagged with its row/column position.
//   master: drives out_data/out_row/out_col/out_last/out_valid, reads out_ready
//   slave : consumer side
interface result_requantizer_if
    import npu_pkg::*;
#(
    parameter int OUT_W = NPU_OUT_W
);
    logic [OUT_W-1:0] out_data;
    logic [1:0]       out_row;
    logic [1:0]       out_col;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data, out_row, out_col, out_last, out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data, out_row, out_col, out_last, out_valid,
        output out_ready
    );
endinterface

// File: rtl/result_requantizer_requant_unit.sv
// requant_unit: combinational shift / optional round / saturate of one
// accumulator element.
//   x : IN_W unsigned accumulator element
//   s : right-shift amount
//   y : OUT_W result, clamped to 2^OUT_W-1
// Build option: define REQUANT_ROUND_EN for round-half-up (adds 2^(s-1)
// before shifting); otherwise the shift truncates.
module requant_unit
    import npu_pkg::*;
#(
    parameter int IN_W    = NPU_IN_W,
    parameter int OUT_W   = NPU_OUT_W,
    parameter int SHIFT_W = NPU_SHIFT_W
) (
    input  logic [IN_W-1:0]    x,
    input  logic [SHIFT_W-1:0] s,
    output logic [OUT_W-1:0]   y
);
    // One spare bit so the rounding add of a full-scale element cannot wrap.
    localparam int MID_W = IN_W + 1;
    localparam logic [MID_W-1:0] SAT = {{(MID_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    logic [MID_W-1:0] bias;
    logic [MID_W-1:0] shifted;

`ifdef REQUANT_ROUND_EN
    // (1 << s) >> 1 is 2^(s-1) for s>0 and 0 for s=0.
    assign bias = (MID_W'(1) << s) >> 1;
`else
    assign bias = '0;
`endif

    always_comb begin
        shifted = ({1'b0, x} + bias) >> s;
        y       = (shifted > SAT) ? SAT[OUT_W-1:0] : shifted[OUT_W-1:0];
    end

endmodule

// File: rtl/result_requantizer.sv
// result_requantizer: captures a 4x4 accumulator tile on the rising edge of
// mm_done and streams it out row-major, one requantized element per handshake.
//   clk, rst        : clock, synchronous active-high reset
//   c_in            : 4x4 unsigned result tile, c_in[row][col]
//   mm_done         : multiplier done level; its rising edge starts a frame
//   shift_amt       : right-shift, sampled with the tile
//   os (master)     : out_data/out_row/out_col/out_last/out_valid/out_ready
//   busy            : frame in progress (LOAD/STREAM/FIN)
//   frame_done      : one-cycle pulse after the last element is accepted
//   overrun         : sticky; a start edge arrived while a frame was active
// Build option: REQUANT_ROUND_EN selects rounding in requant_unit.
module result_requantizer
    import npu_pkg::*;
#(
    parameter int IN_W    = NPU_IN_W,
    parameter int OUT_W   = NPU_OUT_W,
    parameter int SHIFT_W = NPU_SHIFT_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0][3:0][IN_W-1:0]     c_in,
    input  logic                          mm_done,
    input  logic [SHIFT_W-1:0]            shift_amt,
    result_requantizer_if.master          os,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          overrun
);
    rq_state_e                  state_q, state_d;
    logic                       mm_done_q;
    logic [15:0][IN_W-1:0]      mat_q, mat_d;       // element k = row*4+col
    logic [SHIFT_W-1:0]         shift_q, shift_d;
    logic [3:0]                 idx_q, idx_d;       // index of presented element
    logic [OUT_W-1:0]           data_q, data_d;
    logic [1:0]                 row_q, row_d;
    logic [1:0]                 col_q, col_d;
    logic                       last_q, last_d;
    logic                       valid_q, valid_d;
    logic                       overrun_q, overrun_d;

    logic                       start_edge;
    logic [3:0]                 sel_idx;
    logic [IN_W-1:0]            rq_x;
    logic [OUT_W-1:0]           rq_y;

    assign start_edge = mm_done && !mm_done_q;

    // The single requant unit always works on the element to be registered
    // next: element 0 during LOAD, otherwise the successor of the current one.
    assign sel_idx = (state_q == LOAD) ? 4'd0 : idx_q + 4'd1;
    assign rq_x    = mat_q[sel_idx];

    requant_unit #(
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .SHIFT_W (SHIFT_W)
    ) u_requant (
        .x (rq_x),
        .s (shift_q),
        .y (rq_y)
    );

    always_comb begin
        state_d   = state_q;
        mat_d     = mat_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        data_d    = data_q;
        row_d     = row_q;
        col_d     = col_q;
        last_d    = last_q;
        valid_d   = valid_q;
        overrun_d = overrun_q | (start_edge && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    mat_d   = c_in;
                    shift_d = shift_amt;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                idx_d   = 4'd0;
                data_d  = rq_y;
                row_d   = 2'd0;
                col_d   = 2'd0;
                last_d  = 1'b0;
                valid_d = 1'b1;
                state_d = STREAM;
            end
            STREAM: begin
                if (valid_q && os.out_ready) begin
                    if (idx_q == 4'd15) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = FIN;
                    end else begin
                        idx_d  = sel_idx;
                        data_d = rq_y;
                        row_d  = sel_idx[3:2];
                        col_d  = sel_idx[1:0];
                        last_d = (sel_idx == 4'd15);
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mm_done_q <= 1'b0;
            mat_q     <= '0;
            shift_q   <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            last_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mm_done_q <= mm_done;
            mat_q     <= mat_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            row_q     <= row_d;
            col_q     <= col_d;
            last_q    <= last_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign os.out_data  = data_q;
    assign os.out_row   = row_q;
    assign os.out_col   = col_q;
    assign os.out_last  = last_q;
    assign os.out_valid = valid_q;
    assign busy         = (state_q != IDLE);
    assign frame_done   = (state_q == FIN);
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_result_requantizer.sv
module tb_result_requantizer;
    import npu_pkg::*;

    localparam int IN_W    = 16;
    localparam int OUT_W   = 8;
    localparam int SHIFT_W = 4;
`ifdef REQUANT_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      mm_done;
    logic [3:0][3:0][IN_W-1:0] c_in;
    logic [SHIFT_W-1:0]        shift_amt;
    logic                      busy, frame_done, overrun;
    logic [OUT_W-1:0]          got [16];
    int                        n_cmp = 0;
    int                        n_err = 0;

    always #5 clk = ~clk;

    result_requantizer_if #(.OUT_W(OUT_W)) rq_if ();

    result_requantizer #(
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .SHIFT_W (SHIFT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .c_in       (c_in),
        .mm_done    (mm_done),
        .shift_amt  (shift_amt),
        .os         (rq_if),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_all(input logic [IN_W-1:0] v);
        for (int k = 0; k < 16; k++) c_in[k/4][k%4] = v;
    endtask

    task automatic set_el(input int k, input logic [IN_W-1:0] v);
        c_in[k/4][k%4] = v;
    endtask

    // Edge cycle, then LOAD (c_in scribbled to prove capture), then first valid.
    task automatic start_frame(input logic [SHIFT_W-1:0] s);
        shift_amt = s;
        mm_done   = 1'b1;
        tick;
        mm_done   = 1'b0;
        set_all(16'h5A5A);
        shift_amt = 4'd0;
        chk("load_busy", busy, 1);
        chk("load_valid", rq_if.out_valid, 0);
        tick;
        chk("first_valid", rq_if.out_valid, 1);
    endtask

    // Accepts 16 elements on consecutive cycles with ready high.
    task automatic drain_collect;
        for (int k = 0; k < 16; k++) begin
            chk("drn_valid", rq_if.out_valid, 1);
            chk("drn_row", rq_if.out_row, k / 4);
            chk("drn_col", rq_if.out_col, k % 4);
            chk("drn_last", rq_if.out_last, (k == 15) ? 1 : 0);
            got[k] = rq_if.out_data;
            tick;
        end
        chk("fin_valid", rq_if.out_valid, 0);
        chk("fin_done", frame_done, 1);
        tick;
        chk("idle_done", frame_done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; mm_done = 1'b0; shift_amt = '0; rq_if.out_ready = 1'b1;
        set_all('0);
        repeat (2) tick;
        chk("rst_valid", rq_if.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_data", rq_if.out_data, 0);
        chk("rst_last", rq_if.out_last, 0);
        rst = 1'b0;
        tick;

        // All 100, shift 2: 16 x 25, back to back, done at edge+18.
        set_all(16'd100);
        start_frame(4'd2);
        drain_collect;
        for (int k = 0; k < 16; k++) chk("a_data", got[k], 25);

        // Shift 0: pass-through with saturation.
        set_all('0);
        set_el(0, 16'hFFFF); set_el(1, 16'd5); set_el(2, 16'd256); set_el(3, 16'd255);
        start_frame(4'd0);
        drain_collect;
        chk("s0_ffff", got[0], 255);
        chk("s0_5", got[1], 5);
        chk("s0_256", got[2], 255);
        chk("s0_255", got[3], 255);
        chk("s0_zero", got[9], 0);

        // Shift 4.
        set_all('0);
        set_el(0, 16'h0FFF); set_el(1, 16'hFFFF); set_el(2, 16'h0010);
        set_el(3, 16'h0018); set_el(4, 16'h0008);
        start_frame(4'd4);
        drain_collect;
        chk("s4_0fff", got[0], 255);
        chk("s4_ffff", got[1], 255);
        chk("s4_16", got[2], 1);
        chk("s4_24", got[3], RND ? 2 : 1);
        chk("s4_8", got[4], RND ? 1 : 0);

        // Shift 2 and shift 1 rounding points.
        set_all('0);
        set_el(0, 16'd6); set_el(1, 16'd100);
        start_frame(4'd2);
        drain_collect;
        chk("s2_6", got[0], RND ? 2 : 1);
        chk("s2_100", got[1], 25);

        set_all('0);
        set_el(0, 16'd5); set_el(1, 16'd4);
        start_frame(4'd1);
        drain_collect;
        chk("s1_5", got[0], RND ? 3 : 2);
        chk("s1_4", got[1], 2);

        // Shift 15: rounding add on a full-scale element stays in range.
        set_all('0);
        set_el(0, 16'hFFFF); set_el(1, 16'h4000);
        start_frame(4'd15);
        drain_collect;
        chk("s15_ffff", got[0], RND ? 2 : 1);
        chk("s15_4000", got[1], RND ? 1 : 0);

        // Backpressure: ready low 3 cycles while (1,2) is presented.
        for (int k = 0; k < 16; k++) set_el(k, IN_W'(k + 10));
        start_frame(4'd0);
        for (int k = 0; k < 16; k++) begin
            if (k == 6) begin
                rq_if.out_ready = 1'b0;
                repeat (3) begin
                    tick;
                    chk("bp_valid", rq_if.out_valid, 1);
                    chk("bp_data", rq_if.out_data, 16);
                    chk("bp_row", rq_if.out_row, 1);
                    chk("bp_col", rq_if.out_col, 2);
                    chk("bp_last", rq_if.out_last, 0);
                end
                rq_if.out_ready = 1'b1;
            end
            chk("bp_seq_data", rq_if.out_data, k + 10);
            chk("bp_seq_row", rq_if.out_row, k / 4);
            chk("bp_seq_col", rq_if.out_col, k % 4);
            chk("bp_seq_last", rq_if.out_last, (k == 15) ? 1 : 0);
            tick;
        end
        chk("bp_fin_done", frame_done, 1);
        chk("bp_fin_valid", rq_if.out_valid, 0);
        tick;

        // Second edge mid-stream: overrun, frame unchanged, no extra frame.
        for (int k = 0; k < 16; k++) set_el(k, IN_W'(k + 10));
        start_frame(4'd0);
        chk("ov_pre", overrun, 0);
        for (int k = 0; k < 16; k++) begin
            if (k == 4) begin
                set_all(16'd77);
                mm_done = 1'b1;
            end
            chk("ov_data", rq_if.out_data, k + 10);
            chk("ov_valid", rq_if.out_valid, 1);
            tick;
            if (k == 4) chk("ov_set", overrun, 1);
        end
        chk("ov_fin_done", frame_done, 1);
        tick;
        repeat (4) tick;
        chk("ov_no_extra_busy", busy, 0);
        chk("ov_no_extra_valid", rq_if.out_valid, 0);
        mm_done = 1'b0;
        tick;
        chk("ov_sticky", overrun, 1);

        // Reset during STREAM at element 7, mm_done held high across it.
        for (int k = 0; k < 16; k++) set_el(k, IN_W'(k + 10));
        start_frame(4'd0);
        repeat (7) tick;
        chk("rs_elem7", rq_if.out_data, 17);
        set_all(16'd40);
        shift_amt = 4'd1;
        rst = 1'b1;
        mm_done = 1'b1;
        tick;
        chk("rs_valid", rq_if.out_valid, 0);
        chk("rs_busy", busy, 0);
        chk("rs_done", frame_done, 0);
        chk("rs_overrun", overrun, 0);
        chk("rs_data", rq_if.out_data, 0);
        rst = 1'b0;
        tick;
        chk("rs_restart_busy", busy, 1);
        chk("rs_restart_valid", rq_if.out_valid, 0);
        tick;
        drain_collect;
        for (int k = 0; k < 16; k++) chk("rs_new_data", got[k], 20);
        mm_done = 1'b0;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
